store_buffer: RTL and testbench

- Word-store write buffer directly upstream of data_memory in the memory stage.
- Accepts stores from the pipeline into an in-order FIFO and drains one entry per cycle into data_memory's single port.
- Loads take priority on that port and are serviced with store-to-load forwarding from pending entries.
- Decouples store issue from memory-port availability.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/store_buffer_if.sv | 43 ++++
 rtl/store_buffer_match.sv | 36 +++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-stage definitions: word geometry, default store-buffer
// depth and the store-entry layout used by the store buffer.
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;
  // Bit position where the word index starts: addr[AW-1:WORD_LSB].
  localparam int WORD_LSB   = $clog2(WORD_BYTES);

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // One pending store at the default address/data geometry.
  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the pipeline, the store buffer and data_memory.
// master: pipeline/memory side, slave: store buffer.
interface store_buffer_if
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_stall;
  logic          ld_fwd;

  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    input  st_ready, ld_data, ld_stall, ld_fwd, mem_write, mem_address,
           mem_write_data, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    output st_ready, ld_data, ld_stall, ld_fwd, mem_write, mem_address,
           mem_write_data, empty, count
  );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-first address matcher over the circular store buffer.
// Entries are visited oldest (head) to youngest, so the last hit wins.
module store_buffer_match
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  parameter  int IW    = SB_AW - WORD_LSB,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [IW-1:0]    ld_word,
  input  logic [IW-1:0]    entry_word [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  output logic             hit,
  output logic [PW-1:0]    hit_index
);

  logic [PW-1:0] idx;

  // Age-ordered scan; a later (younger) match overrides an earlier one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can hold a stale value (no latch).
    hit       = 1'b0;
    hit_index = head;
    idx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: blocking assignments here are intentional: the loop relies on in-order overwrite.
      idx = head + PW'(i);
      if (valid[idx] && (entry_word[idx] == ld_word)) begin
        hit       = 1'b1;
        hit_index = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order word-store write buffer in front of data_memory's single port.
// Loads own the port unless the buffer is full or a load must wait for a
// matching entry to drain. Build option STORE_BUFFER_FORWARD_EN: when
// defined, loads hitting a pending store are forwarded from the buffer;
// otherwise such loads stall until the matching entries have drained.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = AW - WORD_LSB;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [IW-1:0]    entry_word [DEPTH];

  logic          full;
  logic          is_empty;
  logic          push;
  logic          drain_go;
  logic          stall_cond;
  logic          hit;
  logic [PW-1:0] hit_index;

  assign full     = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);
  // Acceptance uses the pre-drain count, so a full buffer refuses even while draining.
  assign push     = bus.st_valid && !full;

  // Word-index view of each entry; byte offset bits never take part in matching.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_word[i] = addr_q[i][AW-1:WORD_LSB];
  end

  store_buffer_match #(.DEPTH(DEPTH), .IW(IW)) u_match (
    .ld_word    (bus.ld_addr[AW-1:WORD_LSB]),
    .entry_word (entry_word),
    .valid      (valid),
    .head       (head),
    .hit        (hit),
    .hit_index  (hit_index)
  );

`ifdef STORE_BUFFER_FORWARD_EN
  assign stall_cond = 1'b0;
`else
  // Without forwarding, a load may only read memory once no pending store covers its word.
  assign stall_cond = bus.ld_valid && hit;
`endif

  // Drain whenever the port is not taken by a serviceable load; never on a reset cycle.
  assign drain_go = !reset && !is_empty && (!bus.ld_valid || full || stall_cond);

  assign bus.st_ready       = !full;
  assign bus.empty          = is_empty;
  assign bus.count          = cnt;
  assign bus.mem_write      = drain_go;
  assign bus.mem_address    = drain_go ? addr_q[head] : bus.ld_addr;
  assign bus.mem_write_data = data_q[head];
  assign bus.ld_stall       = bus.ld_valid && (full || stall_cond);

`ifdef STORE_BUFFER_FORWARD_EN
  logic fwd_sel;
  assign fwd_sel     = bus.ld_valid && !drain_go && hit;
  assign bus.ld_fwd  = fwd_sel;
  assign bus.ld_data = fwd_sel ? data_q[hit_index] : bus.mem_read_data;
`else
  assign bus.ld_fwd  = 1'b0;
  assign bus.ld_data = bus.mem_read_data;
`endif

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (drain_go) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push && !drain_go)      cnt <= cnt + 1'b1;
      else if (!push && drain_go) cnt <= cnt - 1'b1;
    end
  end

  // Entry payload capture at the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; valid bits alone decide whether an entry exists.
    if (push) begin
      addr_q[tail] <= bus.st_addr;
      data_q[tail] <= bus.st_data;
    end
  end

  // A reported hit must always point at a live entry.
  assert property (@(posedge clk) disable iff (reset) hit |-> valid[hit_index]);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of pending stores and a shadow memory.
module tb_store_buffer;
  import mips_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) sb ();
  store_buffer    #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [64];  // data_memory, written only by the DUT
  logic [31:0] ref_mem [64];  // what memory must hold per the model
  sb_entry_t   q [$];         // pending stores, oldest first
  logic        exp_drain = 1'b0;
  logic        exp_push  = 1'b0;

  // data_memory: combinational read, write on the clock edge.
  assign sb.mem_read_data = mem[sb.mem_address[7:2]];
  always @(posedge clk) begin
    if (sb.mem_write === 1'b1) mem[sb.mem_address[7:2]] <= sb.mem_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model (outputs sampled on the falling edge).
  always @(negedge clk) begin : compare
    int          n;
    bit          full, hit, stall_c, drain, fwd, stall;
    logic [31:0] hd;
    if (reset) begin
      check("mem_write_in_reset", 32'(sb.mem_write), 32'd0);
      exp_drain = 1'b0;
      exp_push  = 1'b0;
    end else begin
      n    = q.size();
      full = (n == DEPTH);
      hit  = 1'b0;
      hd   = '0;
      foreach (q[i]) begin
        if (q[i].addr[31:2] == sb.ld_addr[31:2]) begin
          hit = 1'b1;
          hd  = q[i].data;
        end
      end
      stall_c = !FWD && sb.ld_valid && hit;
      drain   = (n > 0) && (!sb.ld_valid || full || stall_c);
      stall   = sb.ld_valid && (full || stall_c);
      fwd     = FWD && sb.ld_valid && !drain && hit;

      check("count",    32'(sb.count),    32'(n));
      check("empty",    32'(sb.empty),    32'(n == 0));
      check("st_ready", 32'(sb.st_ready), 32'(!full));
      check("mem_write", 32'(sb.mem_write), 32'(drain));
      check("mem_address", sb.mem_address, drain ? q[0].addr : sb.ld_addr);
      if (drain) check("mem_write_data", sb.mem_write_data, q[0].data);
      check("ld_stall", 32'(sb.ld_stall), 32'(stall));
      check("ld_fwd",   32'(sb.ld_fwd),   32'(fwd));
      if (sb.ld_valid && !stall)
        check("ld_data", sb.ld_data, fwd ? hd : ref_mem[sb.ld_addr[7:2]]);

      exp_drain = drain;
      exp_push  = sb.st_valid && !full;
    end
  end

  // Model update on the clock edge: drain oldest into shadow memory, append accepted store.
  always @(posedge clk) begin : model
    sb_entry_t e;
    if (reset) begin
      q.delete();
    end else begin
      if (exp_drain) begin
        ref_mem[q[0].addr[7:2]] = q[0].data;
        void'(q.pop_front());
      end
      if (exp_push) begin
        e.valid = 1'b1;
        e.addr  = sb.st_addr;
        e.data  = sb.st_data;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input bit stv, input logic [31:0] sta, input logic [31:0] std,
                       input bit ldv, input logic [31:0] lda);
    sb.st_valid = stv;
    sb.st_addr  = sta;
    sb.st_data  = std;
    sb.ld_valid = ldv;
    sb.ld_addr  = lda;
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic step(input bit stv, input logic [31:0] sta, input logic [31:0] std,
                      input bit ldv, input logic [31:0] lda);
    @(posedge clk);
    #1;
    drive(stv, sta, std, ldv, lda);
    @(negedge clk);
  endtask

  task automatic drain_all();
    int k = 0;
    while (sb.empty !== 1'b1 && k < 20) begin
      step(1'b0, '0, '0, 1'b0, '0);
      k++;
    end
    check("drain_within_bound", 32'(sb.empty), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_empty",    32'(sb.empty),     32'd1);
    check("rst_st_ready", 32'(sb.st_ready),  32'd1);
    check("rst_count",    32'(sb.count),     32'd0);
    check("rst_mem_write", 32'(sb.mem_write), 32'd0);
    check("rst_ld_stall", 32'(sb.ld_stall),  32'd0);
    check("rst_ld_fwd",   32'(sb.ld_fwd),    32'd0);

    // Two stores, no loads: back-to-back drains at 0 then 4.
    step(1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, '0);
    check("t1_idle_mw", 32'(sb.mem_write), 32'd0);
    step(1'b1, 32'd4, 32'h0FFF_FFFF, 1'b0, '0);
    check("t1_mw0",   32'(sb.mem_write), 32'd1);
    check("t1_addr0", sb.mem_address,    32'd0);
    step(1'b0, '0, '0, 1'b0, '0);
    check("t1_mw1",   32'(sb.mem_write), 32'd1);
    check("t1_addr1", sb.mem_address,    32'd4);
    check("t1_wd1",   sb.mem_write_data, 32'h0FFF_FFFF);
    step(1'b0, '0, '0, 1'b0, '0);
    check("t1_mw_done", 32'(sb.mem_write), 32'd0);
    check("t1_empty",   32'(sb.empty),     32'd1);
    check("t1_mem0", mem[0], 32'hFFFF_FFFF);
    check("t1_mem1", mem[1], 32'h0FFF_FFFF);
    step(1'b0, '0, '0, 1'b1, 32'd4);
    check("t1_rd4", sb.ld_data, 32'h0FFF_FFFF);

`ifdef STORE_BUFFER_FORWARD_EN
    // Two stores to word 8 with loads of 8 every cycle: youngest is forwarded, no drain.
    step(1'b1, 32'd8, 32'h00FF_FFFF, 1'b1, 32'd8);
    check("t2_same_cycle_fwd",  32'(sb.ld_fwd), 32'd0);
    check("t2_same_cycle_data", sb.ld_data,     32'hA000_0002);
    step(1'b1, 32'd8, 32'h000F_FFFF, 1'b1, 32'd8);
    check("t2_fwd_a",  32'(sb.ld_fwd), 32'd1);
    check("t2_data_a", sb.ld_data,     32'h00FF_FFFF);
    step(1'b0, '0, '0, 1'b1, 32'd8);
    check("t2_fwd_b",  32'(sb.ld_fwd),    32'd1);
    check("t2_data_b", sb.ld_data,        32'h000F_FFFF);
    check("t2_no_mw",  32'(sb.mem_write), 32'd0);
    step(1'b0, '0, '0, 1'b1, 32'd8);
    check("t2_no_mw2", 32'(sb.mem_write), 32'd0);
    drain_all();
    check("t2_mem_youngest", mem[2], 32'h000F_FFFF);
`endif

    // Fill with a load of 32 held: full forces a stall and a drain of the head.
    step(1'b1, 32'd0,  32'hC0DE_0000, 1'b1, 32'd32);
    step(1'b1, 32'd4,  32'hC0DE_0004, 1'b1, 32'd32);
    step(1'b1, 32'd8,  32'hC0DE_0008, 1'b1, 32'd32);
    step(1'b1, 32'd12, 32'hC0DE_000C, 1'b1, 32'd32);
    check("t3_cnt3_ready", 32'(sb.st_ready), 32'd1);
    step(1'b1, 32'd16, 32'hDEAD_0010, 1'b1, 32'd32);
    check("t3_count4",  32'(sb.count),     32'd4);
    check("t3_ready0",  32'(sb.st_ready),  32'd0);
    check("t3_stall",   32'(sb.ld_stall),  32'd1);
    check("t3_drain",   32'(sb.mem_write), 32'd1);
    check("t3_head",    sb.mem_address,    32'd0);
    step(1'b0, '0, '0, 1'b1, 32'd32);
    check("t3_count3",  32'(sb.count),     32'd3);
    check("t3_unstall", 32'(sb.ld_stall),  32'd0);
    check("t3_mem0",    mem[0],            32'hC0DE_0000);
    drain_all();
    check("t3_refused_not_written", mem[4], 32'hA000_0004);

    // Store and load word 12 together on an empty buffer: the load sees old memory.
    step(1'b1, 32'd12, 32'h0000_FFFF, 1'b1, 32'd12);
    check("t4_old_data", sb.ld_data,     32'hC0DE_000C);
    check("t4_old_fwd",  32'(sb.ld_fwd), 32'd0);
`ifdef STORE_BUFFER_FORWARD_EN
    step(1'b0, '0, '0, 1'b1, 32'd12);
    check("t4_fwd",  32'(sb.ld_fwd), 32'd1);
    check("t4_data", sb.ld_data,     32'h0000_FFFF);
    drain_all();
`else
    step(1'b0, '0, '0, 1'b1, 32'd12);
    check("t4_stall",      32'(sb.ld_stall), 32'd1);
    check("t4_stall_addr", sb.mem_address,   32'd12);
    step(1'b0, '0, '0, 1'b1, 32'd12);
    check("t4_unstall", 32'(sb.ld_stall), 32'd0);
    check("t4_data",    sb.ld_data,       32'h0000_FFFF);
    // Pending 0x1234_5678@16, load 16 stalls until drained, then reads memory.
    step(1'b1, 32'd16, 32'h1234_5678, 1'b1, 32'd32);
    check("t6_no_stall", 32'(sb.ld_stall), 32'd0);
    step(1'b0, '0, '0, 1'b1, 32'd16);
    check("t6_stall", 32'(sb.ld_stall), 32'd1);
    step(1'b0, '0, '0, 1'b1, 32'd16);
    check("t6_unstall", 32'(sb.ld_stall), 32'd0);
    check("t6_data",    sb.ld_data,       32'h1234_5678);
    check("t6_fwd",     32'(sb.ld_fwd),   32'd0);
`endif

    // Reset with three pending stores while draining.
    step(1'b1, 32'd40, 32'h1111_0028, 1'b1, 32'd60);
    step(1'b1, 32'd44, 32'h2222_002C, 1'b1, 32'd60);
    step(1'b1, 32'd48, 32'h3333_0030, 1'b1, 32'd60);
    step(1'b0, '0, '0, 1'b0, '0);
    check("t5_count3",  32'(sb.count),     32'd3);
    check("t5_draining", 32'(sb.mem_write), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_no_write_in_reset", 32'(sb.mem_write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_empty",  32'(sb.empty),     32'd1);
    check("t5_count",  32'(sb.count),     32'd0);
    check("t5_mw",     32'(sb.mem_write), 32'd0);
    check("t5_mem40",  mem[10], 32'h1111_0028);
    check("t5_mem44",  mem[11], 32'hA000_000B);
    check("t5_mem48",  mem[12], 32'hA000_000C);

    // Randomized traffic over a small word set so loads often hit pending stores.
    for (int c = 0; c < 3000; c++) begin
      bit          rst_now;
      bit          stv, ldv;
      logic [31:0] sta, lda;
      int          ld_pct;
      rst_now = ($urandom_range(0, 299) == 0);
      ld_pct  = ((c / 250) % 2 == 0) ? 40 : 80;
      stv     = ($urandom_range(0, 99) < 60);
      ldv     = ($urandom_range(0, 99) < ld_pct);
      sta     = 32'($urandom_range(0, 7)) * 32'd4;
      lda     = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      reset = rst_now;
      drive(stv, sta, $urandom, ldv, lda);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    drain_all();
    for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
